// File: rtl/uart_ack_pkg.sv
// Shared state encoding, frame layout and checksum helper for the UART ack framer.
// Defining UART_ACK_CHECKSUM_EN inserts a checksum byte before the tail (8-byte frame).
package uart_ack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] func;
    logic [7:0] arg0;
    logic [7:0] arg1;
    logic [7:0] arg2;
    logic [7:0] status;
  } frame_t;

  localparam int FRAME_LEN_PLAIN = 7;
  localparam int FRAME_LEN_CSUM  = 8;

`ifdef UART_ACK_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  function automatic logic [7:0] frame_checksum(input frame_t f);
    return f.func + f.arg0 + f.arg1 + f.arg2 + f.status;
  endfunction

  // Byte at position idx of the frame; anything past the payload is the tail.
  function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] idx,
                                            input logic [7:0] hdr, input logic [7:0] tail);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = f.func;
      3'd2:    b = f.arg0;
      3'd3:    b = f.arg1;
      3'd4:    b = f.arg2;
      3'd5:    b = f.status;
`ifdef UART_ACK_CHECKSUM_EN
      3'd6:    b = frame_checksum(f);
`endif
      default: b = tail;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_ack_buf.sv
// Active frame buffer plus one-deep pending buffer for queued ack requests.
// promote_i moves the pending snapshot into the active buffer while a new one may be captured.
module uart_ack_buf
  import uart_ack_pkg::*;
(
  input  logic   clk_50M,
  input  logic   rst_n,
  input  frame_t fields_i,
  input  logic   cap_cur_i,
  input  logic   cap_pend_i,
  input  logic   promote_i,
  output frame_t cur_o
);

  frame_t cur_q, cur_d;
  frame_t pend_q, pend_d;

  always_comb begin
    cur_d  = cur_q;
    pend_d = pend_q;
    if (promote_i)
      cur_d = pend_q;
    else if (cap_cur_i)
      cur_d = fields_i;
    if (cap_pend_i)
      pend_d = fields_i;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      pend_q <= '0;
    end else begin
      cur_q  <= cur_d;
      pend_q <= pend_d;
    end
  end

  assign cur_o = cur_q;

endmodule

// File: rtl/uart_ack_framer.sv
// Sends a fixed-layout ack frame over a byte UART transmitter, one request queued, extras dropped.
// Optional checksum byte controlled by UART_ACK_CHECKSUM_EN (see uart_ack_pkg).
module uart_ack_framer
  import uart_ack_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE     = 8'h80,
  parameter logic [7:0] TAIL_BYTE    = 8'h55,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] func,
  input  logic [7:0] arg0,
  input  logic [7:0] arg1,
  input  logic [7:0] arg2,
  input  logic [7:0] status,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       framing,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] drop_cnt
);

  localparam logic [2:0]  LAST_IDX = 3'(FRAME_LEN - 1);
  localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [15:0] tmo_q;
  logic        pending_q;
  logic        tx_en_q, framing_q, frame_done_q, frame_err_q;
  logic [7:0]  tx_data_q, drop_cnt_q;

  frame_t fields_c, cur_frame;
  logic   timeout_c, finish_c, restart_c, cap_cur_c, cap_pend_c, promote_c, drop_c;

  assign fields_c = {func, arg0, arg1, arg2, status};

  // A frame "finishes" either normally (DONE) or by busy timeout; both hand over to the queued request.
  always_comb begin
    timeout_c  = (state_q == ST_WAIT_HI) && !tx_busy && (tmo_q == TMO_LAST);
    finish_c   = (state_q == ST_DONE) || timeout_c;
    restart_c  = finish_c && (pending_q || req);
    promote_c  = finish_c && pending_q;
    cap_cur_c  = req && ((state_q == ST_IDLE) || (finish_c && !pending_q));
    cap_pend_c = req && (state_q != ST_IDLE) && (finish_c ? pending_q : !pending_q);
    drop_c     = req && (state_q != ST_IDLE) && !finish_c && pending_q;
  end

  uart_ack_buf u_buf (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .fields_i   (fields_c),
    .cap_cur_i  (cap_cur_c),
    .cap_pend_i (cap_pend_c),
    .promote_i  (promote_c),
    .cur_o      (cur_frame)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      tmo_q        <= 16'd0;
      pending_q    <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= 8'd0;
      framing_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (drop_c && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;

      if (cap_pend_c)
        pending_q <= 1'b1;
      else if (finish_c)
        pending_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q   <= ST_LOAD;
            framing_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          idx_q   <= 3'd0;
          state_q <= ST_START;
        end
        ST_START: begin
          if (!tx_busy) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= frame_byte(cur_frame, idx_q, HDR_BYTE, TAIL_BYTE);
            tmo_q     <= 16'd0;
            state_q   <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_LO;
          end else if (timeout_c) begin
            frame_err_q <= 1'b1;
            idx_q       <= 3'd0;
            framing_q   <= restart_c;
            state_q     <= restart_c ? ST_LOAD : ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              framing_q    <= 1'b0;
              state_q      <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_START;
            end
          end
        end
        ST_DONE: begin
          idx_q     <= 3'd0;
          framing_q <= restart_c;
          state_q   <= restart_c ? ST_LOAD : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign framing    = framing_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_uart_ack_framer.sv
// Self-checking bench for uart_ack_framer: frame-level model plus a per-cycle compare process.
// Build with UART_ACK_CHECKSUM_EN defined to exercise the 8-byte frame.
`timescale 1ns/1ps
module tb_uart_ack_framer;

  localparam logic [7:0] HDR  = 8'h80;
  localparam logic [7:0] TAIL = 8'h55;
`ifdef UART_ACK_CHECKSUM_EN
  localparam int EXP_LEN = 8;
  logic [7:0] lit [8] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h0A, 8'h55};
`else
  localparam int EXP_LEN = 7;
  logic [7:0] lit [7] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h55};
`endif

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       req     = 1'b0;
  logic [7:0] func = 8'd0, arg0 = 8'd0, arg1 = 8'd0, arg2 = 8'd0, status = 8'd0;
  logic       tx_busy;
  logic       tx_en, framing, frame_done, frame_err;
  logic [7:0] tx_data, drop_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int done_cnt = 0, err_cnt = 0, txen_cnt = 0, frame_bytes = 0, last_txen_cyc = 0;
  logic [7:0] held_data = 8'd0;

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_en.
  bit busy_en   = 1'b1;
  int busy_len  = 10;
  int busy_left = 0;

  always #10 clk_50M = ~clk_50M;

  uart_ack_framer #(
    .HDR_BYTE     (8'h80),
    .TAIL_BYTE    (8'h55),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .req        (req),
    .func       (func),
    .arg0       (arg0),
    .arg1       (arg1),
    .arg2       (arg2),
    .status     (status),
    .tx_busy    (tx_busy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .framing    (framing),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .drop_cnt   (drop_cnt)
  );

  always @(posedge clk_50M) begin
    cyc <= cyc + 1;
    if (busy_en && tx_en)
      busy_left <= busy_len;
    else if (busy_left != 0)
      busy_left <= busy_left - 1;
  end
  assign tx_busy = busy_en && (busy_left != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected frame from the field values: header, payload, optional sum, tail.
  task automatic push_frame(input logic [7:0] f, a0, a1, a2, st);
    logic [7:0] sum;
    sum = f + a0 + a1 + a2 + st;
    exp_q.push_back(HDR);
    exp_q.push_back(f);
    exp_q.push_back(a0);
    exp_q.push_back(a1);
    exp_q.push_back(a2);
    exp_q.push_back(st);
`ifdef UART_ACK_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    exp_q.push_back(TAIL);
  endtask

  task automatic send_req(input logic [7:0] f, a0, a1, a2, st);
    @(negedge clk_50M);
    func = f; arg0 = a0; arg1 = a1; arg2 = a2; status = st;
    req = 1'b1;
    @(negedge clk_50M);
    req = 1'b0;
    func = ~f; arg0 = ~a0; arg1 = ~a1; arg2 = ~a2; status = ~st;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk_50M);
      n++;
    end
    check("frame_done within budget", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx_en"}, 32'(tx_en), 32'd0);
    check({tag, " tx_data"}, 32'(tx_data), 32'd0);
    check({tag, " framing"}, 32'(framing), 32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    check({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  // Per-cycle compare against the frame model.
  always @(negedge clk_50M) begin
    if (!rst_n) begin
      frame_bytes = 0;
      held_data   = 8'd0;
    end else begin
      if (tx_en) begin
        txen_cnt++;
        last_txen_cyc = cyc;
        frame_bytes++;
        rx_log.push_back(tx_data);
        held_data = tx_data;
        check("tx_en while busy", 32'(tx_busy), 32'd0);
        check("tx_en expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          check("tx byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (tx_busy)
        check("tx_data stable", 32'(tx_data), 32'(held_data));
      if (frame_done) begin
        done_cnt++;
        $display("[TB] frame %0d done at cycle %0d, %0d bytes", done_cnt, cyc, frame_bytes);
        check("frame length", 32'(frame_bytes), 32'(EXP_LEN));
        check("framing low at done", 32'(framing), 32'd0);
        frame_bytes = 0;
      end
      if (frame_err) begin
        err_cnt++;
        $display("[TB] frame_err at cycle %0d", cyc);
        check("err latency", 32'(cyc - last_txen_cyc), 32'd16);
        check("framing low at err", 32'(framing), 32'd0);
        frame_bytes = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, start, ecnt;

    // Reset state
    repeat (3) @(negedge clk_50M);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50M);

    // Basic frame against hand-computed bytes
    rx_log.delete();
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    send_req(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    wait_done(1, 400);
    repeat (5) @(negedge clk_50M);
    check("t1 byte count", 32'(rx_log.size()), 32'(EXP_LEN));
    for (int i = 0; i < EXP_LEN; i++)
      check($sformatf("t1 byte %0d", i), 32'(rx_log[i]), 32'(lit[i]));
    check("t1 single frame_done", 32'(done_cnt), 32'd1);
    check("t1 queue drained", 32'(exp_q.size()), 32'd0);

    // Three requests 5 cycles apart: two frames, one drop
    base = done_cnt;
    push_frame(8'h10, 8'h11, 8'h12, 8'h13, 8'h14);
    push_frame(8'h20, 8'h21, 8'h22, 8'h23, 8'h24);
    send_req(8'h10, 8'h11, 8'h12, 8'h13, 8'h14);
    repeat (3) @(negedge clk_50M);
    send_req(8'h20, 8'h21, 8'h22, 8'h23, 8'h24);
    repeat (3) @(negedge clk_50M);
    send_req(8'h30, 8'h31, 8'h32, 8'h33, 8'h34);
    wait_done(base + 2, 800);
    repeat (20) @(negedge clk_50M);
    check("t2 drop_cnt", 32'(drop_cnt), 32'd1);
    check("t2 frame count", 32'(done_cnt), 32'(base + 2));
    check("t2 queue drained", 32'(exp_q.size()), 32'd0);

    // 300 drops while framing with a pending request: saturate at 255, pending untouched
    base = done_cnt;
    busy_len = 100;
    push_frame(8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
    push_frame(8'h51, 8'h52, 8'h53, 8'h54, 8'h55);
    send_req(8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
    send_req(8'h51, 8'h52, 8'h53, 8'h54, 8'h55);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50M);
      func = 8'(i); arg0 = 8'(i + 1); arg1 = 8'(i + 2); arg2 = 8'(i + 3); status = 8'(i + 4);
      req = 1'b1;
    end
    @(negedge clk_50M);
    req = 1'b0;
    check("t3 drop_cnt saturated", 32'(drop_cnt), 32'd255);
    wait_done(base + 2, 3000);
    busy_len = 10;
    repeat (5) @(negedge clk_50M);
    check("t3 drop_cnt held", 32'(drop_cnt), 32'd255);
    check("t3 queue drained", 32'(exp_q.size()), 32'd0);

    // Reset during byte 3
    base = done_cnt;
    push_frame(8'h61, 8'h62, 8'h63, 8'h64, 8'h65);
    start = rx_log.size();
    send_req(8'h61, 8'h62, 8'h63, 8'h64, 8'h65);
    n = 0;
    while (rx_log.size() < start + 3 && n < 500) begin
      @(negedge clk_50M);
      n++;
    end
    check("t4 reached byte 3", 32'(rx_log.size() >= start + 3), 32'd1);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b0;
    @(negedge clk_50M);
    check_reset_outputs("t4 mid-frame reset");
    exp_q.delete();
    @(negedge clk_50M);
    rst_n = 1'b1;
    ecnt = txen_cnt;
    repeat (200) @(negedge clk_50M);
    check("t4 no tx_en after reset", 32'(txen_cnt - ecnt), 32'd0);
    check("t4 no frame_done", 32'(done_cnt), 32'(base));
    check("t4 framing low", 32'(framing), 32'd0);
    push_frame(8'h71, 8'h72, 8'h73, 8'h74, 8'h75);
    send_req(8'h71, 8'h72, 8'h73, 8'h74, 8'h75);
    wait_done(base + 1, 400);
    repeat (5) @(negedge clk_50M);
    check("t4 queue drained", 32'(exp_q.size()), 32'd0);

    // Busy never rises: timeout after the header byte
    base = done_cnt;
    n = err_cnt;
    ecnt = txen_cnt;
    busy_en = 1'b0;
    exp_q.push_back(HDR);
    send_req(8'h81, 8'h82, 8'h83, 8'h84, 8'h85);
    start = 0;
    while (err_cnt == n && start < 200) begin
      @(negedge clk_50M);
      start++;
    end
    repeat (30) @(negedge clk_50M);
    check("t5 one frame_err", 32'(err_cnt - n), 32'd1);
    check("t5 one tx_en", 32'(txen_cnt - ecnt), 32'd1);
    check("t5 no frame_done", 32'(done_cnt), 32'(base));
    check("t5 framing low", 32'(framing), 32'd0);
    check("t5 queue drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_ack_framer.md
UART_ACK_FRAMER -- requirements
Module: uart_ack_framer

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'h80, first byte of every ack frame.
REQ-002 SHALL have parameter TAIL_BYTE, default 8'h55, last byte of every ack frame.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16, max clk_50M cycles from tx_en to tx_busy rise.
REQ-004 SHALL have port clk_50M  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  1  one-cycle pulse: send one ack (driven by packet-done of the multi-byte receiver).
REQ-007 SHALL have port func  input  8  function code echoed in the frame.
REQ-008 SHALL have port arg0, arg1, arg2  input  8 each  payload bytes echoed in the frame.
REQ-009 SHALL have port status  input  8  status byte placed after the payload.
REQ-010 SHALL have port tx_busy  input  1  busy from the byte UART transmitter.
REQ-011 SHALL have port tx_en  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 SHALL have port tx_data  output  8  byte to transmit, stable from tx_en until tx_busy falls.
REQ-013 SHALL have port framing  output  1  high from frame load until the last byte completes.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last byte completes.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse on busy timeout.
REQ-016 SHALL have port drop_cnt  output  8  count of dropped requests, saturating at 255.

Function
REQ-017 SHALL, on req, snapshot func/arg0-2/status into a frame buffer in the same cycle; later input changes do not affect the frame.
REQ-018 SHALL send frame order HDR_BYTE, func, arg0, arg1, arg2, status, [checksum], TAIL_BYTE.
REQ-019 SHALL use state machine IDLE -> LOAD -> START -> WAIT_HI -> WAIT_LO -> (START | DONE) -> IDLE.
REQ-020 SHALL, in START, drive tx_data from the byte index and assert tx_en for exactly one cycle, then enter WAIT_HI.
REQ-021 SHALL, in WAIT_HI, go to WAIT_LO on tx_busy=1; after BUSY_TIMEOUT cycles without it, pulse frame_err, abort frame, go IDLE.
REQ-022 SHALL, in WAIT_LO, on tx_busy=0 increment byte index; go START if bytes remain, else DONE.
REQ-023 SHALL pulse frame_done in DONE and deassert framing the same cycle.
REQ-024 SHALL hold one pending request: req while framing sets pending and snapshots into a second buffer; in DONE or on abort with pending set, go LOAD from the second buffer without visiting IDLE.
REQ-025 SHALL drop req while framing and pending both set, increment drop_cnt (saturating at 255), and leave the pending buffer unchanged.
REQ-026 SHALL treat req in the DONE cycle as pending, not dropped.
REQ-027 SHALL never assert tx_en while tx_busy=1 is sampled in START; START waits until tx_busy=0.

Reset
REQ-028 SHALL on rst_n=0 force IDLE, tx_en=0, tx_data=0, framing=0, frame_done=0, frame_err=0, drop_cnt=0, pending=0, index=0.
REQ-029 SHALL, on reset mid-frame, discard the frame and pending request; no tx_en after release until a new req.

Configuration
REQ-030 SHALL with macro UART_ACK_CHECKSUM_EN defined insert checksum = 8-bit modulo-256 sum of func, arg0, arg1, arg2 and status before TAIL_BYTE (8-byte frame).
REQ-031 SHALL without UART_ACK_CHECKSUM_EN send a 7-byte frame with no checksum byte.

Structure
REQ-032 SHALL place state encodings, frame-length constants (7/8) and checksum function in shared package uart_ack_pkg.
REQ-033 SHALL implement the frame buffer plus pending buffer as sub-module uart_ack_buf; the FSM stays in uart_ack_framer.

Verification
REQ-034 SHALL check: req with func=01, args 02/03/04, status 00, busy model 10 cycles -> bytes 80 01 02 03 04 00 0A 55 (checksum on), frame_done once.
REQ-035 SHALL check: same stimulus without UART_ACK_CHECKSUM_EN -> 80 01 02 03 04 00 55.
REQ-036 SHALL check: tx_busy tied 0 -> frame_err pulse 16 cycles after first tx_en, framing low, IDLE.
REQ-037 SHALL check: three req pulses 5 cycles apart -> two frames back-to-back, drop_cnt=1.
REQ-038 SHALL check: 300 dropped reqs -> drop_cnt holds 255.
REQ-039 SHALL check: rst_n low during byte 3 -> all outputs zero, no further tx_en until new req.
